serial_frame_tx: RTL and testbench
==================================

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter WIDTH, default 8, number of payload bits per frame (WIDTH >= 2).
REQ-002 Parameter HDR, default 3'b101, 3-bit header sent MSB-first before every payload.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low (0 = reset asserted); the only reset.
REQ-005 start  input  1  frame request; sampled on the rising edge of clk.
REQ-006 abort  input  1  synchronous frame cancel, active-high.
REQ-007 data_in  input  WIDTH  payload; captured on the edge that accepts start.
REQ-008 x_out  output  1  serial bit stream, the x_in feed of the sequence-detector FSMs.
REQ-009 x_valid  output  1  high while x_out carries a header or payload bit.
REQ-010 busy  output  1  high in every state other than IDLE.
REQ-011 done  output  1  one-cycle pulse after the last payload bit.

Function
REQ-012 The module SHALL use four states: IDLE, HEADER, DATA and DONE, all registered and all outputs registered.
REQ-013 In IDLE: x_out=0, x_valid=0, busy=0, done=0.
REQ-014 start=1 and abort=0 in IDLE at an edge: capture data_in into the shift register, load header counter = 2, enter HEADER.
REQ-015 HEADER: x_out=HDR[cnt], x_valid=1, busy=1; cnt decrements each edge; leaving cnt=0 enters DATA with bit counter = WIDTH-1.
REQ-016 DATA: x_out=shift register MSB, x_valid=1, busy=1; shift left one bit per edge (LSB fill 0); leaving bit counter=0 enters DONE.
REQ-017 DONE: done=1, busy=1, x_valid=0, x_out=0 for exactly one cycle, then IDLE unconditionally.
REQ-018 Timing, with cycle 1 following the start-accepting edge: header in cycles 1-3, payload MSB..LSB in cycles 4..3+WIDTH, done in cycle 4+WIDTH, IDLE in cycle 5+WIDTH.
REQ-019 start in HEADER, DATA or DONE SHALL be ignored; data_in changes after capture SHALL not affect the frame.
REQ-020 The earliest next frame is start sampled in the first IDLE cycle, giving back-to-back frames with one idle cycle between them.
REQ-021 abort=1 in HEADER, DATA or DONE: enter IDLE at the next edge; no done pulse; counters cleared.
REQ-022 abort=1 and start=1 together in IDLE: abort wins and the state stays IDLE.
REQ-023 Counter width: ceil(log2(WIDTH)) bits minimum; no wrap is allowed within a frame.

Reset
REQ-024 reset=0 SHALL force IDLE immediately, without waiting for clk: x_out=0, x_valid=0, busy=0, done=0, shift register and counters = 0.
REQ-025 Reset asserted mid-frame SHALL discard the frame; no done pulse is emitted.
REQ-026 After reset deassertion, the first rising edge may accept start.
REQ-027 Reset deassertion SHALL not by itself produce x_valid or done.

Verification (WIDTH=8, HDR=3'b101)
REQ-028 Pulse start with data_in=8'hA5 -> x_out cycles 1-11 = 1,0,1,1,0,1,0,0,1,0,1; x_valid=1 in cycles 1-11; done=1 only in cycle 12; busy=0 in cycle 13.
REQ-029 Hold start high continuously with data_in=8'hFF -> frames repeat every 13 cycles; each frame is 1,0,1 followed by eight 1s; exactly one idle cycle between frames.
REQ-030 Start with 8'h3C, then data_in=8'h00 in cycle 2 and start pulses in cycles 5 and 9 -> payload still 0,0,1,1,1,1,0,0; no restart.
REQ-031 Start with 8'h81, abort=1 in cycle 6 -> IDLE in cycle 7, x_valid=0, done never asserted; new start in cycle 7 -> full correct frame.
REQ-032 Start with 8'hC3, drive reset=0 between edges in cycle 5 -> outputs zero immediately; after release, no done, and the next start -> full correct frame.
REQ-033 start=1 with abort=1 in IDLE -> busy stays 0 and x_valid stays 0.

Source files
------------

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_tx
// Purpose  : Sends a 3-bit header then a WIDTH-bit payload, MSB-first, with
//            a valid strobe and a one-cycle done pulse; all outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_tx #(
  parameter int         WIDTH = 8,
  parameter logic [2:0] HDR   = 3'b101
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] data_in,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  // One down-counter serves both phases: header needs 2, payload needs WIDTH-1.
  localparam int                 c_CNT_W    = ($clog2(WIDTH) < 2) ? 2 : $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_HDR_TOP  = c_CNT_W'(2);
  localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEADER = 2'd1,
    S_DATA   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_shift;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_x_out;
  logic               r_x_valid;
  logic               r_busy;
  logic               r_done;

  logic [c_CNT_W-1:0] w_cnt_dec;
  logic [1:0]         w_hdr_idx;

  assign w_cnt_dec = r_cnt - c_ONE;
  assign w_hdr_idx = w_cnt_dec[1:0];

  assign x_out   = r_x_out;
  assign x_valid = r_x_valid;
  assign busy    = r_busy;
  assign done    = r_done;

  // Outputs are loaded with the values belonging to the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_x_out   <= 1'b0;
      r_x_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (r_state != S_IDLE && abort) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_x_out   <= 1'b0;
      r_x_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_state   <= S_HEADER;
            r_shift   <= data_in;
            r_cnt     <= c_HDR_TOP;
            r_x_out   <= HDR[2];
            r_x_valid <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_HEADER: begin
          if (r_cnt != '0) begin
            r_cnt   <= w_cnt_dec;
            r_x_out <= HDR[w_hdr_idx];
          end else begin
            r_state <= S_DATA;
            r_cnt   <= c_LAST_BIT;
            r_x_out <= r_shift[WIDTH-1];
          end
        end
        S_DATA: begin
          if (r_cnt != '0) begin
            r_cnt   <= w_cnt_dec;
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            r_x_out <= r_shift[WIDTH-2];
          end else begin
            r_state   <= S_DONE;
            r_x_out   <= 1'b0;
            r_x_valid <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_x_out   <= 1'b0;
          r_x_valid <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// Bench for serial_frame_tx: directed frames plus random traffic, checked every
// cycle against a frame-position model of the expected serial stream.
module tb_serial_frame_tx;

  localparam int         W   = 8;
  localparam logic [2:0] HDR = 3'b101;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         abort;
  logic [W-1:0] data_in;
  logic         x_out;
  logic         x_valid;
  logic         busy;
  logic         done;

  serial_frame_tx #(.WIDTH(W), .HDR(HDR)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .data_in (data_in),
    .x_out   (x_out),
    .x_valid (x_valid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc      = 0;
  int           base     = 0;
  // Model: mdl_k is the position inside the current frame (0 = idle).
  int           mdl_k    = 0;
  logic [W-1:0] mdl_d    = '0;
  logic [63:0]  cap;
  int           cap_n;
  int           done_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] expected();
    logic [2:0]   h;
    logic [W-1:0] d;
    logic         xo;
    xo = 1'b0;
    h  = HDR;
    d  = mdl_d;
    if (mdl_k >= 1 && mdl_k <= 3) begin
      h  = h >> (3 - mdl_k);
      xo = h[0];
    end else if (mdl_k >= 4 && mdl_k <= W + 3) begin
      d  = d >> (W + 3 - mdl_k);
      xo = d[0];
    end
    return {xo, (mdl_k >= 1 && mdl_k <= W + 3), (mdl_k != 0), (mdl_k == W + 4)};
  endfunction

  task automatic model_step();
    if (!reset)                    mdl_k = 0;
    else if (mdl_k == 0) begin
      if (start && !abort) begin
        mdl_k = 1;
        mdl_d = data_in;
      end
    end
    else if (abort || mdl_k == W + 4) mdl_k = 0;
    else                           mdl_k++;
  endtask

  task automatic clear_cap();
    cap   = '0;
    cap_n = 0;
    done_q.delete();
  endtask

  task automatic run(input int n);
    logic [3:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      model_step();
      @(negedge clk);
      e = expected();
      check("x_out",   64'(x_out),   64'(e[3]));
      check("x_valid", 64'(x_valid), 64'(e[2]));
      check("busy",    64'(busy),    64'(e[1]));
      check("done",    64'(done),    64'(e[0]));
      if (x_valid === 1'b1) begin
        cap = {cap[62:0], x_out};
        cap_n++;
      end
      if (done === 1'b1) done_q.push_back(cyc);
      #1;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_x_out"},   64'(x_out),   64'd0);
    check({tag, "_x_valid"}, 64'(x_valid), 64'd0);
    check({tag, "_busy"},    64'(busy),    64'd0);
    check({tag, "_done"},    64'(done),    64'd0);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    data_in = '0;
    clear_cap();
    #1 reset = 1'b0;
    #1 check_zero("rst");
    run(2);
    reset = 1'b1;
    run(2);

    // Single frame A5
    start = 1'b1; data_in = 8'hA5; clear_cap();
    run(1); base = cyc; start = 1'b0;
    run(12);
    check("a5_nbits", 64'(cap_n), 64'd11);
    check("a5_bits",  64'(cap[10:0]), 64'(11'b10110100101));
    check("a5_ndone", 64'(done_q.size()), 64'd1);
    check("a5_done_cyc", 64'(done_q[0]), 64'(base + 11));
    check("a5_busy13", 64'(busy), 64'd0);

    // Start held high: back-to-back frames
    start = 1'b1; data_in = 8'hFF; clear_cap();
    run(1); base = cyc;
    run(38);
    start = 1'b0;
    check("ff_ndone", 64'(done_q.size()), 64'd3);
    check("ff_done0", 64'(done_q[0]), 64'(base + 11));
    check("ff_period", 64'(done_q[1] - done_q[0]), 64'd13);
    check("ff_nbits", 64'(cap_n), 64'd33);
    check("ff_bits", 64'(cap[32:0]), 64'({3{11'b10111111111}}));
    run(2);

    // Captured payload is immune to data_in changes and stray starts
    start = 1'b1; data_in = 8'h3C; clear_cap();
    run(1);
    for (int c = 1; c <= 12; c++) begin
      start   = (c == 5 || c == 9);
      data_in = '0;
      run(1);
    end
    start = 1'b0;
    check("3c_nbits", 64'(cap_n), 64'd11);
    check("3c_bits", 64'(cap[10:0]), 64'(11'b10100111100));
    check("3c_ndone", 64'(done_q.size()), 64'd1);
    check("3c_busy", 64'(busy), 64'd0);
    run(2);

    // Abort mid-frame, then a fresh frame
    start = 1'b1; data_in = 8'h81; clear_cap();
    run(1); start = 1'b0;
    run(5);
    abort = 1'b1;
    run(1);
    check("ab_busy", 64'(busy), 64'd0);
    check("ab_valid", 64'(x_valid), 64'd0);
    check("ab_ndone", 64'(done_q.size()), 64'd0);
    abort = 1'b0; start = 1'b1; data_in = 8'h5A; clear_cap();
    run(1); start = 1'b0;
    run(12);
    check("ab2_bits", 64'(cap[10:0]), 64'(11'b10101011010));
    check("ab2_nbits", 64'(cap_n), 64'd11);
    check("ab2_ndone", 64'(done_q.size()), 64'd1);

    // Asynchronous reset mid-frame
    start = 1'b1; data_in = 8'hC3; clear_cap();
    run(1); start = 1'b0;
    run(4);
    reset = 1'b0; mdl_k = 0;
    #1 check_zero("mid_rst");
    run(1);
    check("rst_ndone", 64'(done_q.size()), 64'd0);
    reset = 1'b1; start = 1'b1; data_in = 8'hC3; clear_cap();
    run(1); start = 1'b0;
    run(12);
    check("c3_bits", 64'(cap[10:0]), 64'(11'b10111000011));
    check("c3_nbits", 64'(cap_n), 64'd11);
    check("c3_ndone", 64'(done_q.size()), 64'd1);

    // Abort beats start in IDLE
    start = 1'b1; abort = 1'b1;
    run(3);
    check("sa_busy", 64'(busy), 64'd0);
    check("sa_valid", 64'(x_valid), 64'd0);
    start = 1'b0; abort = 1'b0;
    run(1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (!reset) begin
        if ($urandom_range(0, 1) == 0) reset = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        mdl_k = 0;
      end
      start   = ($urandom_range(0, 3) == 0);
      abort   = ($urandom_range(0, 39) == 0);
      data_in = W'($urandom);
      run(1);
    end
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    run(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
